uart_rx: RTL and testbench

UART receiver; the downstream partner of the team's UART transmitter.
- Deserialises an asynchronous 8N1 serial line (idle high, LSB first) into bytes.
- Presents each byte with a receive-data-register-full flag, plus framing and overrun error flags.
- Consumed by a host-side reader via a single-cycle read strobe.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_sync.sv | 36 +++
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, frame geometry and default bit timing.
// Imported by both the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial pin, plus one history flop
// so the receiver can detect a high-to-low transition of the synchronised line.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic rx_in,
  output logic rx_s,
  output logic fall_edge
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rx_in};
    rx_prev_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to 1 so a reset with the line idle never looks like a start edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value.
    if (clr) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= sync_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign fall_edge = ~sync_q[SYNC_STAGES-1] & rx_prev_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a host-side data register with
// full, framing-error and overrun flags, consumed by a one-cycle read strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 rxD,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdrf,
  output logic                 fe,
  output logic                 oe
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic rx_s, fall_edge;

  logic [1:0]           state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic                 stop_q,    stop_d;
  logic                 done_q,    done_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rdrf_q,    rdrf_d;
  logic                 fe_q,      fe_d;
  logic                 oe_q,      oe_d;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .clr       (clr),
    .rx_in     (rxD),
    .rx_s      (rx_s),
    .fall_edge (fall_edge)
  );

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    stop_d    = stop_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;
    rdrf_d    = rdrf_q;
    fe_d      = fe_q;
    oe_d      = oe_q;

    case (state_q)
      ST_IDLE: begin
        if (fall_edge) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == IDX_LAST) state_d = ST_STOP;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          stop_d  = rx_s;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A completing frame takes priority over a plain read.
    if (done_q) begin
      if (!rdrf_q || rd) begin
        rx_data_d = shift_q;
        rdrf_d    = 1'b1;
        fe_d      = ~stop_q;
        if (rd) oe_d = 1'b0;
      end else begin
        oe_d = 1'b1;
      end
    end else if (rd && rdrf_q) begin
      rdrf_d = 1'b0;
      fe_d   = 1'b0;
      oe_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
      rdrf_q    <= 1'b0;
      fe_q      <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      stop_q    <= stop_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
      rdrf_q    <= rdrf_d;
      fe_q      <= fe_d;
      oe_q      <= oe_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rdrf    = rdrf_q;
  assign fe      = fe_q;
  assign oe      = oe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a behavioural serial driver stands in for the
// transmitter, and each scenario compares the host-side outputs to fixed values.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       rxD = 1'b1;
  logic       rd  = 1'b0;
  logic [7:0] rx_data;
  logic       rdrf, fe, oe;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat;

  uart_rx #(.CLKS_PER_BIT(N), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .clr     (clr),
    .rxD     (rxD),
    .rd      (rd),
    .rx_data (rx_data),
    .rdrf    (rdrf),
    .fe      (fe),
    .oe      (oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full 8N1 frame; called at posedge+1, returns at posedge+1 with the line idle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxD = 1'b0;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      rxD = b[i];
      tick(N);
    end
    rxD = stop_bit;
    tick(N);
    rxD = 1'b1;
    tick(4);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    tick(1);
  endtask

  task automatic wait_rdrf(input int t0, input int budget, output int latency);
    latency = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rdrf) begin
        latency = cyc - t0;
        break;
      end
    end
  endtask

  initial begin
    int t0;
    tick(3);
    clr = 1'b0;
    tick(1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rdrf", rdrf, 1'b0);
    check("rst_fe", fe, 1'b0);
    check("rst_oe", oe, 1'b0);

    // 1: 0xAA with latency measurement from the pin's falling edge
    t0 = cyc;
    fork
      send_frame(8'hAA, 1'b1);
      wait_rdrf(t0, 200, lat);
    join
    check("t1_latency_in_window", (lat >= 155 && lat <= 157), 1'b1);
    check("t1_rx_data", rx_data, 8'hAA);
    check("t1_fe", fe, 1'b0);
    check("t1_oe", oe, 1'b0);
    pulse_rd();
    check("t1_rd_clears_rdrf", rdrf, 1'b0);

    // 2: short glitch is a false start, then 0x55
    rxD = 1'b0;
    tick(4);
    rxD = 1'b1;
    tick(30);
    check("t2_no_rdrf", rdrf, 1'b0);
    check("t2_idle", dut.state_q, ST_IDLE);
    send_frame(8'h55, 1'b1);
    check("t2_rdrf", rdrf, 1'b1);
    check("t2_rx_data", rx_data, 8'h55);
    check("t2_fe", fe, 1'b0);
    pulse_rd();

    // 3: bad stop bit sets fe, read clears it
    send_frame(8'h3C, 1'b0);
    check("t3_rdrf", rdrf, 1'b1);
    check("t3_rx_data", rx_data, 8'h3C);
    check("t3_fe", fe, 1'b1);
    pulse_rd();
    check("t3_rd_rdrf", rdrf, 1'b0);
    check("t3_rd_fe", fe, 1'b0);
    check("t3_rd_holds_data", rx_data, 8'h3C);

    // 4: overrun keeps the first byte
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("t4_rx_data", rx_data, 8'h11);
    check("t4_oe", oe, 1'b1);
    check("t4_rdrf", rdrf, 1'b1);
    check("t4_fe", fe, 1'b0);
    pulse_rd();
    check("t4_rd_rdrf", rdrf, 1'b0);
    check("t4_rd_oe", oe, 1'b0);
    check("t4_rd_fe", fe, 1'b0);

    // 5: rd on the completion cycle of 0x22, with 0x11 pending and oe set
    send_frame(8'h11, 1'b1);
    send_frame(8'h33, 1'b1);
    check("t5_pre_oe", oe, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        tick(155);
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
      end
    join
    check("t5_rx_data", rx_data, 8'h22);
    check("t5_rdrf", rdrf, 1'b1);
    check("t5_oe", oe, 1'b0);
    check("t5_fe", fe, 1'b0);
    pulse_rd();
    check("t5_rd_rdrf", rdrf, 1'b0);
    pulse_rd();
    check("t5_idle_rd_data", rx_data, 8'h22);
    check("t5_idle_rd_rdrf", rdrf, 1'b0);

    // 6: clr in the middle of the data bits of 0xF0
    rxD = 1'b0;
    tick(N);
    for (int i = 0; i < 3; i++) begin
      rxD = 1'b0;
      tick(N);
    end
    check("t6_mid_data", dut.state_q, ST_DATA);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    rxD = 1'b1;
    tick(1);
    check("t6_rst_rx_data", rx_data, 8'h00);
    check("t6_rst_rdrf", rdrf, 1'b0);
    check("t6_rst_fe", fe, 1'b0);
    check("t6_rst_oe", oe, 1'b0);
    tick(20);
    check("t6_no_spurious", rdrf, 1'b0);
    send_frame(8'h0F, 1'b1);
    check("t6_rx_data", rx_data, 8'h0F);
    check("t6_rdrf", rdrf, 1'b1);
    check("t6_fe", fe, 1'b0);
    check("t6_oe", oe, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
